os_discard: RTL and testbench

- Overlap-save output stage; sits after the IFFT that follows the overlap-save input buffer.
- Consumes 2N-sample time-domain blocks framed by start/valid and discards the first N (circular-aliased) samples.
- Scales and saturates the last N samples, then delivers them through an output FIFO with a valid/ready handshake.

---
 rtl/os_discard_if.sv | 26 ++
 rtl/os_discard.sv | 167 ++++++++++++++++
 tb/tb_os_discard.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/os_discard_if.sv
// Stream bundle for os_discard: 2N-sample input blocks in, scaled kept samples out.
// The slave modport is the design view; the master modport is the source/sink side.
interface os_discard_if #(
    parameter int WI = 16,
    parameter int WO = 9
);
    logic                 i_valid;
    logic                 i_start;
    logic signed [WI-1:0] i_yI;
    logic signed [WI-1:0] i_yQ;
    logic                 o_valid;
    logic                 i_ready;
    logic signed [WO-1:0] o_yI;
    logic signed [WO-1:0] o_yQ;
    logic                 o_last;

    modport slave (
        input  i_valid, i_start, i_yI, i_yQ, i_ready,
        output o_valid, o_yI, o_yQ, o_last
    );

    modport master (
        output i_valid, i_start, i_yI, i_yQ, i_ready,
        input  o_valid, o_yI, o_yQ, o_last
    );
endinterface

// File: rtl/os_discard.sv
// Overlap-save output stage: drops the first N samples of each 2N block, scales/saturates the rest into a FWFT FIFO.
// Define OS_ROUND_EN for round-half-up scaling; otherwise the shift floors.
module os_discard #(
    parameter int N     = 16,
    parameter int WI    = 16,
    parameter int WO    = 9,
    parameter int SHIFT = 5,
    parameter int DEPTH = 16,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    os_discard_if.slave   bus,
    output logic [CW-1:0] o_count,
    output logic          o_overflow,
    output logic          o_sync_err
);
    localparam int IW = $clog2(2 * N);
    localparam int PW = $clog2(DEPTH);
    localparam logic [IW-1:0] IDX_LAST_DISC = IW'(N - 1);
    localparam logic [IW-1:0] IDX_LAST      = IW'(2 * N - 1);
    localparam logic [CW-1:0] FULL          = CW'(DEPTH);
    localparam logic signed [WI:0] SAT_MAX  = (WI + 1)'((1 << (WO - 1)) - 1);
    localparam logic signed [WI:0] SAT_MIN  = ~SAT_MAX;
`ifdef OS_ROUND_EN
    localparam logic signed [WI:0] RND      = (WI + 1)'((1 << SHIFT) >> 1);
`endif

    typedef enum logic [1:0] {WAIT_START, DISCARD, KEEP} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 sync_err_q, sync_err_d;
    logic signed [WO-1:0] mem_i_q [DEPTH];
    logic signed [WO-1:0] mem_i_d [DEPTH];
    logic signed [WO-1:0] mem_q_q [DEPTH];
    logic signed [WO-1:0] mem_q_d [DEPTH];
    logic                 mem_last_q [DEPTH];
    logic                 mem_last_d [DEPTH];
    logic                 push;
    logic                 pop;
    logic                 wr_ok;

    // Widened by one bit so the rounding offset cannot wrap a full-scale positive input.
    function automatic logic signed [WO-1:0] scale_sat(input logic signed [WI-1:0] y);
        logic signed [WI:0] ext;
        logic signed [WI:0] s;
        ext = {y[WI-1], y};
`ifdef OS_ROUND_EN
        ext = ext + RND;
`endif
        s = ext >>> SHIFT;
        if (s > SAT_MAX) begin
            return $signed(SAT_MAX[WO-1:0]);
        end else if (s < SAT_MIN) begin
            return $signed(SAT_MIN[WO-1:0]);
        end
        return $signed(s[WO-1:0]);
    endfunction

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        sync_err_d = sync_err_q;
        mem_i_d    = mem_i_q;
        mem_q_d    = mem_q_q;
        mem_last_d = mem_last_q;
        push       = 1'b0;
        pop        = (count_q != '0) && bus.i_ready;
        wr_ok      = 1'b0;

        // A start always realigns to index 0 of a new block, even mid-block.
        if (bus.i_valid) begin
            if (bus.i_start) begin
                if (idx_q != '0) begin
                    sync_err_d = 1'b1;
                end
                state_d = DISCARD;
                idx_d   = IW'(1);
            end else begin
                case (state_q)
                    DISCARD: begin
                        if (idx_q == IDX_LAST_DISC) begin
                            state_d = KEEP;
                        end
                        idx_d = idx_q + 1'b1;
                    end
                    KEEP: begin
                        push = 1'b1;
                        if (idx_q == IDX_LAST) begin
                            state_d = WAIT_START;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // A full FIFO still accepts a write when the head leaves in the same cycle.
        if (push) begin
            if ((count_q != FULL) || pop) begin
                wr_ok                = 1'b1;
                mem_i_d[wr_ptr_q]    = scale_sat(bus.i_yI);
                mem_q_d[wr_ptr_q]    = scale_sat(bus.i_yQ);
                mem_last_d[wr_ptr_q] = (idx_q == IDX_LAST);
                wr_ptr_d             = wr_ptr_q + 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end

        if (wr_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!wr_ok && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= WAIT_START;
            idx_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            sync_err_q <= 1'b0;
            mem_i_q    <= '{default: '0};
            mem_q_q    <= '{default: '0};
            mem_last_q <= '{default: 1'b0};
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            sync_err_q <= sync_err_d;
            mem_i_q    <= mem_i_d;
            mem_q_q    <= mem_q_d;
            mem_last_q <= mem_last_d;
        end
    end

    assign bus.o_valid = (count_q != '0);
    assign bus.o_yI    = mem_i_q[rd_ptr_q];
    assign bus.o_yQ    = mem_q_q[rd_ptr_q];
    assign bus.o_last  = mem_last_q[rd_ptr_q];
    assign o_count     = count_q;
    assign o_overflow  = overflow_q;
    assign o_sync_err  = sync_err_q;
endmodule

// File: tb/tb_os_discard.sv
// Scoreboard bench for os_discard: kept-sample expectations are queued as stimulus is driven
// and compared against samples captured whenever the DUT hands one downstream.
module tb_os_discard;
    localparam int N     = 16;
    localparam int WI    = 16;
    localparam int WO    = 9;
    localparam int DEPTH = 16;
    localparam int CW    = 5;
`ifdef OS_ROUND_EN
    localparam int R48 = 2;
`else
    localparam int R48 = 1;
`endif

    typedef logic [2*WO:0] out_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] o_count;
    logic          o_overflow;
    logic          o_sync_err;
    out_t          exp_q[$];
    out_t          got_q[$];
    int            checks = 0;
    int            failures = 0;

    os_discard_if #(.WI(WI), .WO(WO)) bus();

    os_discard #(.N(N), .WI(WI), .WO(WO), .SHIFT(5), .DEPTH(DEPTH)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .bus        (bus),
        .o_count    (o_count),
        .o_overflow (o_overflow),
        .o_sync_err (o_sync_err)
    );

    always #5 clk = ~clk;

    // Inputs settle at posedge+1, so a head seen here with ready high is popped at the next edge.
    always @(negedge clk) begin
        if (rst_n && bus.o_valid && bus.i_ready) begin
            got_q.push_back({bus.o_last, bus.o_yI, bus.o_yQ});
        end
    end

    function automatic out_t mk(input logic last, input int yi, input int yq);
        return {last, WO'(yi), WO'(yq)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic s, input int yi, input int yq);
        bus.i_valid = v;
        bus.i_start = s;
        bus.i_yI    = WI'(yi);
        bus.i_yQ    = WI'(yq);
    endtask

    task automatic send_sample(input logic s, input int yi, input int yq);
        set_in(1'b1, s, yi, yq);
        tick();
    endtask

    // Sample k carries I=sgn*k*32, Q=-sgn*k*32, so kept outputs are +/-k after the shift.
    task automatic send_block(input int sgn, input bit expect_kept);
        for (int k = 0; k < 2 * N; k++) begin
            if (expect_kept && k >= N) exp_q.push_back(mk(k == 2 * N - 1, sgn * k, -sgn * k));
            send_sample(k == 0, sgn * k * 32, -sgn * k * 32);
        end
        set_in(1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b0, 0, 0);
        bus.i_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset();
        set_in(1'b0, 1'b0, 0, 0);
        bus.i_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.o_valid, o_count, o_overflow, o_sync_err, bus.o_last} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_state: got valid=%b count=%0d ovf=%b sync=%b last=%b, expected all 0",
                     bus.o_valid, o_count, o_overflow, o_sync_err, bus.o_last);
        end
        checks++;
        if (bus.o_yI !== '0 || bus.o_yQ !== '0) begin
            failures++;
            $display("[TB] FAIL reset_data: got I=%0d Q=%0d, expected 0 0", bus.o_yI, bus.o_yQ);
        end
        rst_n = 1'b1;
        tick();
        for (int k = 0; k <= 20; k++) send_sample(k == 0, k * 32, k * 32);
        set_in(1'b0, 1'b0, 0, 0);
        tick();
        checks++;
        if (o_count !== 5) begin
            failures++;
            $display("[TB] FAIL prereset_count: got %0d, expected 5", o_count);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_valid !== 1'b0 || o_count !== '0 || o_overflow !== 1'b0 || o_sync_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset: got valid=%b count=%0d ovf=%b sync=%b, expected 0 0 0 0",
                     bus.o_valid, o_count, o_overflow, o_sync_err);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_single_block();
        out_t g, e;
        bus.i_ready = 1'b1;
        for (int k = 0; k < 2 * N; k++) begin
            if (k >= N) exp_q.push_back(mk(k == 2 * N - 1, k, -k));
            send_sample(k == 0, k * 32, -k * 32);
            if (k == N - 1) begin
                checks++;
                if (bus.o_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL latency_before: got valid=%b, expected 0", bus.o_valid);
                end
            end
            if (k == N) begin
                checks++;
                if (bus.o_valid !== 1'b1 || bus.o_yI !== 9'sd16) begin
                    failures++;
                    $display("[TB] FAIL latency_first: got valid=%b I=%0d, expected 1 16", bus.o_valid, bus.o_yI);
                end
            end
        end
        set_in(1'b0, 1'b0, 0, 0);
        repeat (3) tick();
        checks++;
        if (got_q.size() != 16) begin
            failures++;
            $display("[TB] FAIL single_count: got %0d outputs, expected 16", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("[TB] FAIL single_out: got {last,I,Q}=%h, expected %h", g, e);
            end
        end
        checks++;
        if (bus.o_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_empty: got valid=%b, expected 0", bus.o_valid);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_saturation();
        out_t g, e;
        int   yi, yq, ei, eq;
        bus.i_ready = 1'b1;
        for (int k = 0; k < 2 * N; k++) begin
            case (k)
                16: begin yi = 32767;  yq = -32768; ei = 255;  eq = -256; end
                17: begin yi = -32768; yq = 32767;  ei = -256; eq = 255;  end
                18: begin yi = 48;     yq = -17;    ei = R48;  eq = -1;   end
                19: begin yi = -17;    yq = 48;     ei = -1;   eq = R48;  end
                default: begin yi = 0; yq = 0; ei = 0; eq = 0; end
            endcase
            if (k >= N) exp_q.push_back(mk(k == 2 * N - 1, ei, eq));
            send_sample(k == 0, yi, yq);
        end
        set_in(1'b0, 1'b0, 0, 0);
        repeat (3) tick();
        checks++;
        if (got_q.size() != 16) begin
            failures++;
            $display("[TB] FAIL sat_count: got %0d outputs, expected 16", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("[TB] FAIL sat_out: got {last,I,Q}=%h, expected %h", g, e);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_push_pop_full();
        out_t g, e;
        do_reset();
        send_block(1, 1'b1);
        checks++;
        if (o_count !== 16) begin
            failures++;
            $display("[TB] FAIL fill_count: got %0d, expected 16", o_count);
        end
        for (int k = 0; k < N; k++) send_sample(k == 0, -k * 32, k * 32);
        exp_q.push_back(mk(1'b0, -16, 16));
        bus.i_ready = 1'b1;
        send_sample(1'b0, -16 * 32, 16 * 32);
        bus.i_ready = 1'b0;
        set_in(1'b0, 1'b0, 0, 0);
        tick();
        checks++;
        if (o_count !== 16 || o_overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL pushpop_full: got count=%0d ovf=%b, expected 16 0", o_count, o_overflow);
        end
        bus.i_ready = 1'b1;
        repeat (20) tick();
        checks++;
        if (got_q.size() != 17) begin
            failures++;
            $display("[TB] FAIL pushpop_count: got %0d outputs, expected 17", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("[TB] FAIL pushpop_out: got {last,I,Q}=%h, expected %h", g, e);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_overflow();
        out_t g, e;
        do_reset();
        send_block(1, 1'b1);
        checks++;
        if (o_count !== 16 || o_overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ovf_block1: got count=%0d ovf=%b, expected 16 0", o_count, o_overflow);
        end
        send_block(-1, 1'b0);
        checks++;
        if (o_count !== 16 || o_overflow !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovf_block2: got count=%0d ovf=%b, expected 16 1", o_count, o_overflow);
        end
        bus.i_ready = 1'b1;
        repeat (20) tick();
        checks++;
        if (got_q.size() != 16) begin
            failures++;
            $display("[TB] FAIL ovf_count: got %0d outputs, expected 16", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("[TB] FAIL ovf_out: got {last,I,Q}=%h, expected %h", g, e);
            end
        end
        checks++;
        if (bus.o_valid !== 1'b0 || o_overflow !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovf_drained: got valid=%b ovf=%b, expected 0 1", bus.o_valid, o_overflow);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_resync();
        out_t g, e;
        do_reset();
        bus.i_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k >= N) exp_q.push_back(mk(1'b0, k, 3));
            send_sample(k == 0, k * 32, 3 * 32);
        end
        checks++;
        if (o_sync_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL resync_pre: got sync=%b, expected 0", o_sync_err);
        end
        send_sample(1'b1, 5000, 5000);
        checks++;
        if (o_sync_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL resync_flag: got sync=%b, expected 1", o_sync_err);
        end
        for (int j = 1; j < 2 * N; j++) begin
            if (j >= N) exp_q.push_back(mk(j == 2 * N - 1, j, 3));
            send_sample(1'b0, j * 32, 3 * 32);
        end
        set_in(1'b0, 1'b0, 0, 0);
        repeat (3) tick();
        checks++;
        if (got_q.size() != 20) begin
            failures++;
            $display("[TB] FAIL resync_count: got %0d outputs, expected 20", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("[TB] FAIL resync_out: got {last,I,Q}=%h, expected %h", g, e);
            end
        end
        checks++;
        if (o_sync_err !== 1'b1 || bus.o_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL resync_end: got sync=%b valid=%b, expected 1 0", o_sync_err, bus.o_valid);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        $display("[TB] os_discard bench starting");
        test_reset();
        test_single_block();
        test_saturation();
        test_push_pop_full();
        test_overflow();
        test_resync();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
